// File: rtl/iterative_comparator.sv
// Slice-serial operand comparator: scans a and b MSB slice first, then reports
// equality, signed/unsigned ordering and the RV32I branch decision for funct3.
module iterative_comparator #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             a_lt_b_s,
  output logic             a_gt_b_s,
  output logic             a_lt_b_u,
  output logic             a_gt_b_u,
  output logic             taken,
  output logic             illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  typedef struct packed {
    logic equal;
    logic lt_s;
    logic gt_s;
    logic lt_u;
    logic gt_u;
    logic taken;
    logic illegal;
  } result_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       f3_q;
  logic [IDX_W-1:0] idx_q;
  logic             decided_q, decided_d;
  logic             ult_q, ult_d;
  result_t          res_q, res_d;
  logic             accept, step, finish;
  logic [31:0]      shift;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic             first_diff;

  assign shift   = 32'(idx_q) * 32'(CHUNK);
  assign slice_a = CHUNK'(a_q >> shift);
  assign slice_b = CHUNK'(b_q >> shift);
  // Only the first differing slice from the MSB decides the ordering.
  assign first_diff = (slice_a != slice_b) && !decided_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    decided_d = decided_q;
    ult_d     = ult_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          decided_d = 1'b0;
          ult_d     = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (first_diff) begin
          decided_d = 1'b1;
          ult_d     = slice_a < slice_b;
        end
        if ((first_diff && EARLY_EXIT) || idx_q == '0) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      accept  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
    end
  end

  // Result flags are formed from the decision as it stands after this cycle's slice.
  always_comb begin
    res_d      = '0;
    res_d.equal = !decided_d;
    res_d.lt_u  = decided_d & ult_d;
    res_d.gt_u  = decided_d & !ult_d;
    if (a_q[WIDTH-1] != b_q[WIDTH-1]) begin
      res_d.lt_s = a_q[WIDTH-1];
      res_d.gt_s = b_q[WIDTH-1];
    end else begin
      res_d.lt_s = res_d.lt_u;
      res_d.gt_s = res_d.gt_u;
    end
    case (f3_q)
      3'b000:  res_d.taken = res_d.equal;
      3'b001:  res_d.taken = !res_d.equal;
      3'b100:  res_d.taken = res_d.lt_s;
      3'b101:  res_d.taken = !res_d.lt_s;
      3'b110:  res_d.taken = res_d.lt_u;
      3'b111:  res_d.taken = !res_d.lt_u;
      default: res_d.illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      idx_q     <= IDX_TOP;
      decided_q <= 1'b0;
      ult_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      decided_q <= decided_d;
      ult_q     <= ult_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        f3_q  <= funct3;
        idx_q <= IDX_TOP;
      end else if (step) begin
        idx_q <= idx_q - IDX_W'(1);
      end
      if (flush)       res_q <= '0;
      else if (finish) res_q <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign equal     = res_q.equal;
  assign a_lt_b_s  = res_q.lt_s;
  assign a_gt_b_s  = res_q.gt_s;
  assign a_lt_b_u  = res_q.lt_u;
  assign a_gt_b_u  = res_q.gt_u;
  assign taken     = res_q.taken;
  assign illegal   = res_q.illegal;

endmodule

// File: doc/iterative_comparator.md
Name: iterative_comparator

Overview:
- Multi-cycle, parametrised successor to the combinational branch comparators.
- Compares two WIDTH-bit operands in CHUNK-bit slices, MSB slice first. Produces equal, signed and unsigned less-than and greater-than flags, plus a resolved RV32I branch decision for a funct3 code.
- Sits between the register-read stage and the branch unit in multi-cycle and low-area configurations.
- Uses valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits compared per scan cycle. Legal range is 1 to WIDTH. NCHUNK = WIDTH/CHUNK.
- EARLY_EXIT, 1. When 1, scanning stops at the first differing slice. When 0, all NCHUNK slices are always scanned, giving constant latency.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operands and funct3 are valid.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- funct3  input  3  RV32I branch funct3.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- equal  output  1  a == b.
- a_lt_b_s  output  1  signed a < b.
- a_gt_b_s  output  1  signed a > b.
- a_lt_b_u  output  1  unsigned a < b.
- a_gt_b_u  output  1  unsigned a > b.
- taken  output  1  branch condition for funct3.
- illegal  output  1  funct3 is 010 or 011.

Behaviour:
- States: IDLE, SCAN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- Reset: state IDLE. Slice index NCHUNK-1. Captured operands 0. All result flags 0. out_valid 0, in_ready 1.
- IDLE:
  - in_valid & in_ready registers a, b and funct3.
  - Sets the slice index to NCHUNK-1 and the "decided" flag to 0.
  - Goes to SCAN.
- SCAN: each cycle, compare slice idx, i.e. bits [idx*CHUNK +: CHUNK] of the captured a and b, as unsigned values.
  - Slices differ and not yet decided: latch ult = (slice_a < slice_b), set decided = 1.
    - EARLY_EXIT=1: go to DONE.
    - EARLY_EXIT=0: continue scanning. Later slices never change the latched ult.
  - idx == 0 and not yet decided: the operands are equal. Go to DONE.
  - idx == 0 otherwise: go to DONE.
  - All other cases: idx decrements.
- Result flags, registered on entry to DONE:
  - equal = !decided
  - a_lt_b_u = decided & ult
  - a_gt_b_u = decided & !ult
  - If sa != sb (sa, sb are the operand MSBs): a_lt_b_s = sa, a_gt_b_s = sb.
  - Otherwise: a_lt_b_s = a_lt_b_u, a_gt_b_s = a_gt_b_u.
- taken and illegal, decoded from funct3:
  - 000: taken = equal
  - 001: taken = !equal
  - 100: taken = a_lt_b_s
  - 101: taken = !a_lt_b_s
  - 110: taken = a_lt_b_u
  - 111: taken = !a_lt_b_u
  - 010 and 011: taken = 0, illegal = 1. All other codes give illegal = 0.
- Latency from the accept edge to out_valid high is k+1 cycles, where k is the number of SCAN cycles:
  - EARLY_EXIT=1: k is the position of the first differing slice counted from the MSB, 1 to NCHUNK. Equal operands give k = NCHUNK.
  - EARLY_EXIT=0: k = NCHUNK always.
- DONE:
  - Outputs are held stable while out_ready is 0.
  - out_valid & out_ready returns the block to IDLE. No accept in that same cycle, so throughput is at most one result per k+2 cycles.
- flush: in any state, the next state is IDLE. Result flags and out_valid clear to 0. flush has priority over the handshakes.
- rst_n asserted mid-SCAN or in DONE clears everything immediately. No result is emitted.
- a and b changing after accept have no effect.

Test Plan:
1. WIDTH=32, CHUNK=8, EARLY_EXIT=1, a = b = 0xDEADBEEF, funct3=000 -> out_valid 5 cycles after accept; equal=1, all lt/gt=0, taken=1.
2. a=0x80000000, b=0x00000001, funct3=100 -> out_valid 2 cycles after accept; a_lt_b_s=1, a_gt_b_u=1, taken=1. Same operands with funct3=110 -> taken=0.
3. EARLY_EXIT=0, a=0x12345600, b=0x12345601 and also a=0xFF000000, b=0x00000000 -> both give out_valid exactly 5 cycles after accept. First pair: a_lt_b_u=1. Second pair: a_lt_b_s=1, a_gt_b_u=1.
4. Backpressure: hold out_ready=0 for 4 cycles in DONE -> outputs stable, in_ready=0. A new in_valid is ignored until the cycle after the out handshake.
5. flush asserted during the 2nd SCAN cycle -> IDLE next cycle, in_ready=1, no out_valid. A following request completes normally. Repeat the scenario using rst_n instead of flush -> all outputs 0 asynchronously.
6. funct3=011 with any operands -> illegal=1, taken=0. Random sweep over CHUNK in {1, 4, 32}, checked against a golden model of the $signed/$unsigned comparisons -> no mismatches.
